avalon_rsa_dma: RTL and testbench
=================================

// Module: avalon_rsa_dma
// PURPOSE
//  Parametrised Avalon-MM DMA controller for an external rsa_core.
//  Software programs source/destination bases and block count, then sets START.
//  Block loads exponent and modulus once, then per block: fetches a message, runs the core, writes the result back.
//  Sits between the PCIe-visible DRAM (avm_m0) and rsa_core; CSRs live on avs_s0.
// PARAMETERS
//  ADDR_W     32  master byte-address width
//  KEY_BYTES  32  operand size in bytes; power of 2; core_addr width AW=$clog2(KEY_BYTES)
//  CNT_W      16  block-count width, <=32
// PORTS
//  clk                 in   1       system clock
//  reset               in   1       synchronous, active-high
//  avm_m0_waitrequest  in   1       master stall
//  avm_m0_address      out  ADDR_W  byte address
//  avm_m0_read         out  1       read request
//  avm_m0_write        out  1       write request
//  avm_m0_readdata     in   8       read data, valid in the cycle read & !waitrequest
//  avm_m0_writedata    out  8       write data
//  avs_s0_waitrequest  out  1       tied 0
//  avs_s0_address      in   2       CSR select
//  avs_s0_read         in   1       CSR read
//  avs_s0_write        in   1       CSR write
//  avs_s0_readdata     out  32      CSR data, combinational
//  avs_s0_writedata    in   32      CSR write data
//  core_we/core_oe/core_start  out 1  rsa_core controls; start is a 1-cycle pulse
//  core_reg_sel        out  2       10=exponent 11=modulus 01=message/result
//  core_addr           out  AW      byte index within operand
//  core_data_i         out  8       data to core
//  core_data_o         in   8       core result byte, combinational from core_addr while core_oe=1
//  core_ready          in   1       core idle/result valid
// BEHAVIOUR
//  CSR 0 CTRL: wr b0=START, b3=ABORT, b1 W1C DONE, b2 IRQ_EN. Rd b0 BUSY, b1 DONE, b2 IRQ_EN.
//  CSR 1 SRC, 2 DST, 3 COUNT; SRC/DST are ADDR_W wide, COUNT is CNT_W wide. Writes to CSR 1-3 and START are ignored while BUSY.
//  Reset: state IDLE; all avm/core outputs 0; CSRs 0; addresses 0.
//  Layout: E @SRC, N @SRC+K, message b @SRC+(2+b)*K; result b @DST+b*K (K=KEY_BYTES).
//  FSM:
//   IDLE -START-> LD_E, or -> DONE if COUNT==0.
//   LD_E -K bytes-> LD_N.
//   LD_N -K bytes-> LD_M.
//   LD_M -K bytes-> KICK.
//   KICK (one cycle, core_start=1) -> CALC.
//   CALC waits core_ready=1, no earlier than 1 cycle after KICK -> WR.
//   WR -K bytes-> b==COUNT-1 ? DONE : LD_M with b+1.
//   DONE sets DONE=1 for one cycle, then IDLE.
//  Load states: avm_m0_read=1, core_we=1; address and core_addr held while waitrequest=1.
//   Each accepted beat (!waitrequest) drives core_data_i=readdata with core_we for that cycle, then advances by 1.
//  WR: avm_m0_write=1, core_oe=1, writedata=core_data_o; address held while waitrequest=1.
//  BUSY = state != IDLE. DONE is sticky until W1C; START while DONE=1 is allowed.
//  ABORT: finishes the in-flight bus beat (never drops read/write while waitrequest=1), then returns to IDLE; DONE is not set.
//  Byte and block counters use exact width; no wrap. Address wrap at 2^ADDR_W is allowed and unflagged.
//  Simultaneous DONE W1C and DONE set in the same cycle: set wins.
// CONFIGURATION
//  RSA_DMA_IRQ_EN defined: adds port irq (out, 1) = DONE & IRQ_EN, registered.
//  RSA_DMA_IRQ_EN undefined: no irq port; CTRL b2 reads 0 and its writes are ignored.
// TESTING (KEY_BYTES=4, memory and core models)
//  SRC=0x100, DST=0x200, COUNT=1, START:
//   -> reads 0x100-0x10B in order, one core_start, writes 0x200-0x203 with core bytes, DONE=1, BUSY=0.
//  COUNT=3, random waitrequest 50%:
//   -> E/N fetched once; 3 core_start pulses; 12 result writes at 0x200-0x20B; address stable on every stalled cycle.
//  COUNT=0, START:
//   -> no avm_m0 traffic; DONE=1 within 2 cycles.
//  ABORT during WR byte 2 with waitrequest=1 for 3 cycles:
//   -> write held 3 cycles, then IDLE; DONE=0; restart succeeds.
//  Write SRC while BUSY -> SRC unchanged; write CTRL=0x2 after done -> DONE=0.
//  RSA_DMA_IRQ_EN with IRQ_EN=1:
//   -> irq rises 1 cycle after DONE; clears on W1C; synchronous reset mid-LD_N clears all outputs next edge.

Source files
------------

// File: rtl/avalon_rsa_dma.sv
// avalon_rsa_dma
// Avalon-MM DMA engine feeding an external rsa_core. Software programs the
// source/destination bases and a block count on avs_s0, then sets START.
// The exponent and modulus are fetched once; each block then fetches a
// message, kicks the core, waits for the result and writes it back.
//
// Optional feature macro: RSA_DMA_IRQ_EN
//   defined   -> adds output irq = DONE & IRQ_EN (registered), CTRL b2 is R/W
//   undefined -> no irq port, CTRL b2 reads 0 and writes to it are ignored
//
// KEY_BYTES must be a power of two and at least 2; ADDR_W must not exceed 32.

module avalon_rsa_dma #(
  parameter int ADDR_W    = 32,
  parameter int KEY_BYTES = 32,
  parameter int CNT_W     = 16,
  localparam int AW       = $clog2(KEY_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef RSA_DMA_IRQ_EN
  output logic              irq,
`endif
  // DRAM-side master
  input  logic              avm_m0_waitrequest,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  output logic              avm_m0_write,
  input  logic [7:0]        avm_m0_readdata,
  output logic [7:0]        avm_m0_writedata,
  // CSR slave
  output logic              avs_s0_waitrequest,
  input  logic [1:0]        avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  output logic [31:0]       avs_s0_readdata,
  input  logic [31:0]       avs_s0_writedata,
  // rsa_core side
  output logic              core_we,
  output logic              core_oe,
  output logic              core_start,
  output logic [1:0]        core_reg_sel,
  output logic [AW-1:0]     core_addr,
  output logic [7:0]        core_data_i,
  input  logic [7:0]        core_data_o,
  input  logic              core_ready
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LD_E = 3'd1;
  localparam logic [2:0] ST_LD_N = 3'd2;
  localparam logic [2:0] ST_LD_M = 3'd3;
  localparam logic [2:0] ST_KICK = 3'd4;
  localparam logic [2:0] ST_CALC = 3'd5;
  localparam logic [2:0] ST_WR   = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MSG  = 2'b01;
  localparam logic [1:0] SEL_EXP  = 2'b10;
  localparam logic [1:0] SEL_MOD  = 2'b11;

  localparam logic [AW-1:0]     BYTE_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]     BYTE_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]     BYTE_LAST = {AW{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Registers
  logic [2:0]        state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [AW-1:0]     byte_r;
  logic [CNT_W-1:0]  blk_r;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [CNT_W-1:0]  count_r;
  logic              done_r;
  logic              irq_en_r;
  logic              abort_pend_r;

  // Combinational helpers
  logic [2:0] state_nxt_s;
  logic       busy_s;
  logic       ctrl_wr_s;
  logic       start_s;
  logic       abort_req_s;
  logic       load_state_s;
  logic       bus_state_s;
  logic       beat_s;
  logic       last_byte_s;
  logic       last_blk_s;

  assign busy_s       = (state_r != ST_IDLE);
  assign ctrl_wr_s    = avs_s0_write && (avs_s0_address == 2'd0);
  assign start_s      = ctrl_wr_s && avs_s0_writedata[0] && !busy_s;
  // An abort takes effect in the cycle it is written, so no new beat is
  // ever launched after it; a stalled beat keeps the request pending.
  assign abort_req_s  = abort_pend_r || (ctrl_wr_s && avs_s0_writedata[3]);
  assign load_state_s = (state_r == ST_LD_E) || (state_r == ST_LD_N) ||
                        (state_r == ST_LD_M);
  assign bus_state_s  = load_state_s || (state_r == ST_WR);
  assign beat_s       = bus_state_s && !avm_m0_waitrequest;
  assign last_byte_s  = (byte_r == BYTE_LAST);
  assign last_blk_s   = (blk_r == (count_r - CNT_ONE));

  // Next-state decode of the transfer sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if (count_r == CNT_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_LD_E;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LD_E, ST_LD_N, ST_LD_M: begin
        if (beat_s) begin
          if (abort_req_s) begin
            state_nxt_s = ST_IDLE;
          end else if (last_byte_s) begin
            if (state_r == ST_LD_E) begin
              state_nxt_s = ST_LD_N;
            end else if (state_r == ST_LD_N) begin
              state_nxt_s = ST_LD_M;
            end else begin
              state_nxt_s = ST_KICK;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_KICK: begin
        if (abort_req_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_CALC: begin
        // CALC is entered one cycle after the start pulse, so ready seen here
        // already reflects the core having accepted the start.
        if (abort_req_s) begin
          state_nxt_s = ST_IDLE;
        end else if (core_ready) begin
          state_nxt_s = ST_WR;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_WR: begin
        if (beat_s) begin
          if (abort_req_s) begin
            state_nxt_s = ST_IDLE;
          end else if (last_byte_s) begin
            if (last_blk_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_LD_M;
            end
          end else begin
            state_nxt_s = ST_WR;
          end
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and pending-abort flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      abort_pend_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s == ST_IDLE) begin
        abort_pend_r <= 1'b0;
      end else if (abort_req_s && busy_s) begin
        abort_pend_r <= 1'b1;
      end
    end
  end

  // Address pointers, byte index and block counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_r <= ADDR_ZERO;
      wr_addr_r <= ADDR_ZERO;
      byte_r    <= BYTE_ZERO;
      blk_r     <= CNT_ZERO;
    end else if (start_s) begin
      rd_addr_r <= src_r;
      wr_addr_r <= dst_r;
      byte_r    <= BYTE_ZERO;
      blk_r     <= CNT_ZERO;
    end else if (beat_s) begin
      byte_r <= last_byte_s ? BYTE_ZERO : (byte_r + BYTE_ONE);
      if (state_r == ST_WR) begin
        wr_addr_r <= wr_addr_r + ADDR_ONE;
        if (last_byte_s && !last_blk_s) begin
          blk_r <= blk_r + CNT_ONE;
        end
      end else begin
        // E, N and the messages are contiguous, so the read pointer simply
        // keeps running from block to block.
        rd_addr_r <= rd_addr_r + ADDR_ONE;
      end
    end
  end

  // CSR storage: bases and count locked while busy, DONE sticky until W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      src_r    <= ADDR_ZERO;
      dst_r    <= ADDR_ZERO;
      count_r  <= CNT_ZERO;
      done_r   <= 1'b0;
      irq_en_r <= 1'b0;
    end else begin
      if (avs_s0_write && !busy_s) begin
        case (avs_s0_address)
          2'd1:    src_r   <= avs_s0_writedata[ADDR_W-1:0];
          2'd2:    dst_r   <= avs_s0_writedata[ADDR_W-1:0];
          2'd3:    count_r <= avs_s0_writedata[CNT_W-1:0];
          default: ;
        endcase
      end
      // Completion beats a same-cycle clear.
      if (state_r == ST_DONE) begin
        done_r <= 1'b1;
      end else if (ctrl_wr_s && avs_s0_writedata[1]) begin
        done_r <= 1'b0;
      end
`ifdef RSA_DMA_IRQ_EN
      if (ctrl_wr_s) begin
        irq_en_r <= avs_s0_writedata[2];
      end
`endif
    end
  end

`ifdef RSA_DMA_IRQ_EN
  logic irq_r;

  // Registered interrupt: follows DONE one cycle later when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= done_r && irq_en_r;
    end
  end

  assign irq = irq_r;
`endif

  assign avs_s0_waitrequest = 1'b0;

  // CSR read mux
  always_comb begin
    avs_s0_readdata = 32'h0000_0000;
    if (avs_s0_read) begin
      case (avs_s0_address)
        2'd0:    avs_s0_readdata = {29'd0, irq_en_r, done_r, busy_s};
        2'd1:    avs_s0_readdata = 32'(src_r);
        2'd2:    avs_s0_readdata = 32'(dst_r);
        2'd3:    avs_s0_readdata = 32'(count_r);
        default: avs_s0_readdata = 32'h0000_0000;
      endcase
    end else begin
      avs_s0_readdata = 32'h0000_0000;
    end
  end

  // Master and core strobes decoded from the registered state
  always_comb begin
    avm_m0_read     = 1'b0;
    avm_m0_write    = 1'b0;
    avm_m0_address  = ADDR_ZERO;
    avm_m0_writedata = 8'h00;
    core_we         = 1'b0;
    core_oe         = 1'b0;
    core_start      = 1'b0;
    core_reg_sel    = SEL_NONE;
    core_addr       = byte_r;
    core_data_i     = 8'h00;
    case (state_r)
      ST_LD_E, ST_LD_N, ST_LD_M: begin
        avm_m0_read    = 1'b1;
        avm_m0_address = rd_addr_r;
        core_we        = 1'b1;
        if (state_r == ST_LD_E) begin
          core_reg_sel = SEL_EXP;
        end else if (state_r == ST_LD_N) begin
          core_reg_sel = SEL_MOD;
        end else begin
          core_reg_sel = SEL_MSG;
        end
        // Data is only meaningful on the accepted beat; the core simply sees
        // the final value at this index once the beat lands.
        if (!avm_m0_waitrequest) begin
          core_data_i = avm_m0_readdata;
        end else begin
          core_data_i = 8'h00;
        end
      end
      ST_KICK: begin
        core_start   = 1'b1;
        core_reg_sel = SEL_MSG;
      end
      ST_CALC: begin
        core_reg_sel = SEL_MSG;
      end
      ST_WR: begin
        avm_m0_write     = 1'b1;
        avm_m0_address   = wr_addr_r;
        avm_m0_writedata = core_data_o;
        core_oe          = 1'b1;
        core_reg_sel     = SEL_MSG;
      end
      default: begin
        core_reg_sel = SEL_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_rsa_dma.sv
// Directed bench for avalon_rsa_dma with KEY_BYTES=4, a byte-addressed
// memory model and a small rsa_core model. Expected traffic and results are
// computed from the memory function, independently of the DUT.

module tb_avalon_rsa_dma;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        reset;
`ifdef RSA_DMA_IRQ_EN
  logic        irq;
`endif
  logic        avm_m0_waitrequest;
  logic [31:0] avm_m0_address;
  logic        avm_m0_read;
  logic        avm_m0_write;
  logic [7:0]  avm_m0_readdata;
  logic [7:0]  avm_m0_writedata;
  logic        avs_s0_waitrequest;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_readdata;
  logic [31:0] avs_s0_writedata;
  logic        core_we;
  logic        core_oe;
  logic        core_start;
  logic [1:0]  core_reg_sel;
  logic [1:0]  core_addr;
  logic [7:0]  core_data_i;
  logic [7:0]  core_data_o;
  logic        core_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  avalon_rsa_dma #(.ADDR_W(32), .KEY_BYTES(K), .CNT_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
`ifdef RSA_DMA_IRQ_EN
    .irq               (irq),
`endif
    .avm_m0_waitrequest(avm_m0_waitrequest),
    .avm_m0_address    (avm_m0_address),
    .avm_m0_read       (avm_m0_read),
    .avm_m0_write      (avm_m0_write),
    .avm_m0_readdata   (avm_m0_readdata),
    .avm_m0_writedata  (avm_m0_writedata),
    .avs_s0_waitrequest(avs_s0_waitrequest),
    .avs_s0_address    (avs_s0_address),
    .avs_s0_read       (avs_s0_read),
    .avs_s0_write      (avs_s0_write),
    .avs_s0_readdata   (avs_s0_readdata),
    .avs_s0_writedata  (avs_s0_writedata),
    .core_we           (core_we),
    .core_oe           (core_oe),
    .core_start        (core_start),
    .core_reg_sel      (core_reg_sel),
    .core_addr         (core_addr),
    .core_data_i       (core_data_i),
    .core_data_o       (core_data_o),
    .core_ready        (core_ready)
  );

  // Memory contents as a pure function of the byte address
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return (a[7:0] ^ 8'hA5) + {4'h0, a[11:8]};
  endfunction

  // Expected core output for block b, byte i, given the source base
  function automatic logic [7:0] exp_res(input logic [31:0] src, input int b, input int i);
    logic [7:0] e, n, m;
    e = mem_byte(src + 32'(i));
    n = mem_byte(src + 32'(K + i));
    m = mem_byte(src + 32'((2 + b) * K + i));
    return (m ^ e) + n;
  endfunction

  assign avm_m0_readdata = mem_byte(avm_m0_address);

  // rsa_core model: operand registers, 3-cycle busy after start
  logic [7:0] ce [K];
  logic [7:0] cn [K];
  logic [7:0] cm [K];
  logic [7:0] cres [K];
  int         cbusy = 0;

  always @(posedge clk) begin
    if (core_we) begin
      case (core_reg_sel)
        2'b10:   ce[core_addr] <= core_data_i;
        2'b11:   cn[core_addr] <= core_data_i;
        2'b01:   cm[core_addr] <= core_data_i;
        default: ;
      endcase
    end
    if (core_start) begin
      for (int i = 0; i < K; i++) cres[i] <= (cm[i] ^ ce[i]) + cn[i];
      cbusy <= 3;
    end else if (cbusy > 0) begin
      cbusy <= cbusy - 1;
    end
  end

  assign core_ready  = (cbusy == 0);
  assign core_data_o = cres[core_addr];

  // Waitrequest driver: random, forced low, or left to the main thread
  bit rand_mode = 1'b0;
  bit manual    = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) avm_m0_waitrequest = ($urandom_range(0, 1) != 0);
      else if (!manual) avm_m0_waitrequest = 1'b0;
    end
  end

  // Bus monitor, sampled mid-cycle
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];
  int          starts = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (avm_m0_read && !avm_m0_waitrequest) rd_log.push_back(avm_m0_address);
      if (avm_m0_write && !avm_m0_waitrequest) begin
        wr_addr_log.push_back(avm_m0_address);
        wr_data_log.push_back(avm_m0_writedata);
      end
      if (core_start) starts++;
      if (prev_stall && (!(avm_m0_read || avm_m0_write) || (avm_m0_address != prev_addr)))
        stall_err++;
      prev_stall = (avm_m0_read || avm_m0_write) && avm_m0_waitrequest;
      prev_addr  = avm_m0_address;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    starts    = 0;
    stall_err = 0;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_s0_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    #1;
    d = avs_s0_readdata;
    avs_s0_read = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt);
    csr_wr(2'd1, src);
    csr_wr(2'd2, dst);
    csr_wr(2'd3, cnt);
    clear_log();
    csr_wr(2'd0, 32'h1);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] v;
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      csr_rd(2'd0, v);
      n++;
    end while (v[0] && n < budget);
    check("idle_timeout", {31'd0, v[0]}, 32'h0);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] src, input logic [31:0] dst, input int cnt);
    check({tag, "_nwr"}, 32'(wr_addr_log.size()), 32'(cnt * K));
    for (int b = 0; b < cnt; b++) begin
      for (int i = 0; i < K; i++) begin
        if (b * K + i < wr_addr_log.size()) begin
          check({tag, "_waddr"}, wr_addr_log[b * K + i], dst + 32'(b * K + i));
          check({tag, "_wdata"}, {24'd0, wr_data_log[b * K + i]}, {24'd0, exp_res(src, b, i)});
        end
      end
    end
  endtask

  logic [31:0] v;
  int          n;
  bit          found;

  initial begin
    reset              = 1'b1;
    avm_m0_waitrequest = 1'b0;
    avs_s0_address     = 2'd0;
    avs_s0_read        = 1'b0;
    avs_s0_write       = 1'b0;
    avs_s0_writedata   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_read",  {31'd0, avm_m0_read}, 32'h0);
    check("rst_write", {31'd0, avm_m0_write}, 32'h0);
    check("rst_addr",  avm_m0_address, 32'h0);
    check("rst_core",  {26'd0, core_we, core_oe, core_start, core_reg_sel, 1'b0}, 32'h0);
    check("rst_wreq",  {31'd0, avs_s0_waitrequest}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), v);
      check("rst_csr", v, 32'h0);
    end

    // Single block, no stalls
    run_job(32'h100, 32'h200, 32'd1);
    wait_idle(1000);
    check("b1_nrd", 32'(rd_log.size()), 32'd12);
    for (int i = 0; i < rd_log.size(); i++) check("b1_raddr", rd_log[i], 32'h100 + 32'(i));
    check("b1_starts", 32'(starts), 32'd1);
    check_writes("b1", 32'h100, 32'h200, 1);
    csr_rd(2'd0, v);
    check("b1_ctrl", v, 32'h2);
    csr_rd(2'd1, v);
    check("b1_src", v, 32'h100);

    // DONE W1C
    csr_wr(2'd0, 32'h2);
    csr_rd(2'd0, v);
    check("w1c_ctrl", v, 32'h0);

    // Three blocks, random stalls, SRC write while busy is ignored
    rand_mode = 1'b1;
    run_job(32'h100, 32'h200, 32'd3);
    csr_wr(2'd1, 32'h300);
    wait_idle(3000);
    rand_mode = 1'b0;
    check("b3_nrd", 32'(rd_log.size()), 32'd20);
    for (int i = 0; i < rd_log.size(); i++) check("b3_raddr", rd_log[i], 32'h100 + 32'(i));
    check("b3_starts", 32'(starts), 32'd3);
    check("b3_stall", 32'(stall_err), 32'd0);
    check_writes("b3", 32'h100, 32'h200, 3);
    csr_rd(2'd1, v);
    check("busy_src", v, 32'h100);
    csr_rd(2'd0, v);
    check("b3_ctrl", v, 32'h2);

    // COUNT=0: no traffic, DONE within two cycles
    csr_wr(2'd0, 32'h2);
    csr_wr(2'd3, 32'h0);
    clear_log();
    csr_wr(2'd0, 32'h1);
    @(posedge clk);
    #1;
    csr_rd(2'd0, v);
    check("c0_ctrl", v, 32'h2);
    check("c0_nrd", 32'(rd_log.size()), 32'd0);
    check("c0_nwr", 32'(wr_addr_log.size()), 32'd0);
    csr_wr(2'd0, 32'h2);

    // ABORT during WR byte 2 with a 3-cycle stall
    manual = 1'b1;
    avm_m0_waitrequest = 1'b0;
    run_job(32'h100, 32'h200, 32'd1);
    n = 0;
    found = 1'b0;
    while (!found && n < 500) begin
      @(negedge clk);
      found = avm_m0_write && (core_addr == 2'd1);
      n++;
    end
    check("ab_reach", {31'd0, found}, 32'h1);
    @(posedge clk);
    #1;
    avm_m0_waitrequest = 1'b1;
    avs_s0_address     = 2'd0;
    avs_s0_writedata   = 32'h8;
    avs_s0_write       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ab_hold_wr", {31'd0, avm_m0_write}, 32'h1);
      check("ab_hold_addr", avm_m0_address, 32'h202);
      @(posedge clk);
      #1;
      avs_s0_write = 1'b0;
    end
    avm_m0_waitrequest = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    manual = 1'b0;
    @(negedge clk);
    check("ab_rw", {30'd0, avm_m0_read, avm_m0_write}, 32'h0);
    check("ab_nwr", 32'(wr_addr_log.size()), 32'd3);
    csr_rd(2'd0, v);
    check("ab_ctrl", v, 32'h0);

    // Restart after abort, different base addresses and two blocks
    run_job(32'h140, 32'h280, 32'd2);
    wait_idle(2000);
    check("rs_starts", 32'(starts), 32'd2);
    check_writes("rs", 32'h140, 32'h280, 2);
    csr_rd(2'd0, v);
    check("rs_ctrl", v, 32'h2);
    csr_wr(2'd0, 32'h2);

`ifdef RSA_DMA_IRQ_EN
    // IRQ follows DONE one cycle later and clears after W1C
    csr_wr(2'd3, 32'h0);
    csr_wr(2'd0, 32'h5);
    @(posedge clk);
    #1;
    csr_rd(2'd0, v);
    check("irq_ctrl", v, 32'h6);
    check("irq_lag", {31'd0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("irq_set", {31'd0, irq}, 32'h1);
    csr_wr(2'd0, 32'h6);
    @(posedge clk);
    #1;
    check("irq_clr", {31'd0, irq}, 32'h0);
`else
    // CTRL b2 reads back 0 and ignores writes in this configuration
    csr_wr(2'd0, 32'h4);
    csr_rd(2'd0, v);
    check("irqen_ro", v, 32'h0);
`endif

    // Synchronous reset in the middle of LD_N clears everything
    run_job(32'h100, 32'h200, 32'd1);
    n = 0;
    while (core_reg_sel != 2'b11 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rn_reach", {30'd0, core_reg_sel}, 32'h3);
    reset = 1'b1;
    @(negedge clk);
    check("rn_rw", {30'd0, avm_m0_read, avm_m0_write}, 32'h0);
    check("rn_addr", avm_m0_address, 32'h0);
    check("rn_core", {27'd0, core_we, core_oe, core_start, core_reg_sel}, 32'h0);
`ifdef RSA_DMA_IRQ_EN
    check("rn_irq", {31'd0, irq}, 32'h0);
`endif
    csr_rd(2'd1, v);
    check("rn_src", v, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
